pio_reg_slave: RTL and testbench

- PIO endpoint directly downstream of the PIO bus master. One instance per slave index.
- Decodes the serialized PIO bus: a one-cycle start for a read, or two consecutive start cycles for a write (address cycle, then data cycle).
- Performs one access on a local register interface.
- Returns the result as level-held pio_ack / pio_rvalid / pio_rdata, aligned to its own divided-clock strobe clk_div. The master samples these only on clk_div cycles.

---
 rtl/pio_pkg.sv | 19 +
 rtl/pio_clk_div.sv | 34 +++
 rtl/pio_reg_slave.sv | 149 ++++++++++++++
 tb/tb_pio_reg_slave.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared PIO bus types and constants
package pio_pkg;

  localparam int unsigned PIO_W = 32;

  typedef logic [PIO_W-1:0] pio_word_t;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    ACCESS,
    RESP,
    DRAIN
  } pio_slv_state_t;

  // Read data returned when the local register never answers
  localparam pio_word_t PIO_TIMEOUT_DATA = '1;

endpackage

// File: rtl/pio_clk_div.sv
// rtl/pio_clk_div.sv - free-running divided-clock sample strobe
module pio_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic clk_div
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          clk_div_q;

  // Wrap the counter after its last phase
  always_comb begin
    div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + CW'(1);
  end

  // Strobe is registered so it is high in the same cycle the counter sits on its last phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      clk_div_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_div_q <= (div_cnt_d == LAST);
    end
  end

  assign clk_div = clk_div_q;

endmodule

// File: rtl/pio_reg_slave.sv
// rtl/pio_reg_slave.sv - PIO bus endpoint bridging to a local register port
module pio_reg_slave
  import pio_pkg::*;
#(
  parameter int unsigned           PIO_NBITS = PIO_W,
  parameter int unsigned           CLK_DIV   = 4,
  parameter logic [PIO_NBITS-1:0]  BASE_ADDR = 32'h0001_0000,
  parameter logic [PIO_NBITS-1:0]  BASE_MASK = 32'hFFFF_0000,
  parameter int unsigned           REG_AW    = 8,
  parameter int unsigned           TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pio_start,
  input  logic                 pio_rw,
  input  logic [PIO_NBITS-1:0] pio_addr_wdata,
  output logic                 clk_div,
  output logic                 pio_ack,
  output logic                 pio_rvalid,
  output logic [PIO_NBITS-1:0] pio_rdata,
  output logic                 reg_req,
  output logic                 reg_wr,
  output logic [REG_AW-1:0]    reg_addr,
  output logic [PIO_NBITS-1:0] reg_wdata,
  input  logic [PIO_NBITS-1:0] reg_rdata,
  input  logic                 reg_rdy,
  output logic                 pio_err,
  output logic                 pio_drop
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  pio_slv_state_t         state_q;
  logic                   reg_req_q, reg_wr_q;
  logic [REG_AW-1:0]      reg_addr_q;
  logic [PIO_NBITS-1:0]   reg_wdata_q, pio_rdata_q;
  logic                   pio_ack_q, pio_rvalid_q, pio_err_q, pio_drop_q;
  logic [TW-1:0]          to_cnt_q;
  logic                   addr_hit;
  logic                   strobe;

  pio_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk     (clk),
    .rst     (rst),
    .clk_div (strobe)
  );

  assign addr_hit = (pio_addr_wdata & BASE_MASK) == (BASE_ADDR & BASE_MASK);

  // Transaction FSM; every output is a register so the master sees clean levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      reg_req_q    <= 1'b0;
      reg_wr_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      pio_rdata_q  <= '0;
      pio_ack_q    <= 1'b0;
      pio_rvalid_q <= 1'b0;
      pio_err_q    <= 1'b0;
      pio_drop_q   <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      pio_drop_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pio_start && addr_hit) begin
            reg_wr_q   <= pio_rw;
            reg_addr_q <= pio_addr_wdata[REG_AW+1:2];
            if (pio_rw) begin
              state_q <= WDATA;
            end else begin
              state_q   <= ACCESS;
              reg_req_q <= 1'b1;
              to_cnt_q  <= '0;
            end
          end
        end
        WDATA: begin
          // A write without its data cycle is malformed and dropped silently
          if (pio_start) begin
            reg_wdata_q <= pio_addr_wdata;
            reg_req_q   <= 1'b1;
            to_cnt_q    <= '0;
            state_q     <= ACCESS;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          pio_drop_q <= pio_start;
          // A late reg_rdy on the final timeout cycle still counts as a real completion
          if (reg_rdy) begin
            reg_req_q <= 1'b0;
            state_q   <= RESP;
            if (reg_wr_q) begin
              pio_ack_q <= 1'b1;
            end else begin
              pio_rdata_q  <= reg_rdata;
              pio_rvalid_q <= 1'b1;
            end
          end else if (to_cnt_q == TO_LAST) begin
            reg_req_q <= 1'b0;
            pio_err_q <= 1'b1;
            state_q   <= RESP;
            if (reg_wr_q) begin
              pio_ack_q <= 1'b1;
            end else begin
              pio_rdata_q  <= '1;
              pio_rvalid_q <= 1'b1;
            end
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        RESP: begin
          pio_drop_q <= pio_start;
          if (strobe) begin
            pio_ack_q    <= 1'b0;
            pio_rvalid_q <= 1'b0;
            state_q      <= DRAIN;
          end
        end
        DRAIN: begin
          // One full strobe of low levels before the slave can respond again
          pio_drop_q <= pio_start;
          if (strobe) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clk_div    = strobe;
  assign pio_ack    = pio_ack_q;
  assign pio_rvalid = pio_rvalid_q;
  assign pio_rdata  = pio_rdata_q;
  assign reg_req    = reg_req_q;
  assign reg_wr     = reg_wr_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign pio_err    = pio_err_q;
  assign pio_drop   = pio_drop_q;

endmodule

// File: tb/tb_pio_reg_slave.sv
// tb/tb_pio_reg_slave.sv - directed self-checking bench for pio_reg_slave
module tb_pio_reg_slave;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned TIMEOUT = 64;

  logic        clk, rst;
  logic        pio_start, pio_rw;
  logic [31:0] pio_addr_wdata;
  logic        clk_div, pio_ack, pio_rvalid, pio_err, pio_drop;
  logic [31:0] pio_rdata, reg_wdata, reg_rdata;
  logic        reg_req, reg_wr, reg_rdy;
  logic [7:0]  reg_addr;

  logic        rdy_en;
  logic [31:0] mem_rdata;

  // expectations used by the per-cycle compare
  int          k;
  logic [31:0] exp_rdata, exp_wdata;
  logic [7:0]  exp_addr;
  logic        exp_wr;
  int          rv_strb, ack_strb, drop_cyc, req_cyc, ack_cyc;

  int          checks, errors;

  pio_reg_slave #(
    .PIO_NBITS(32), .CLK_DIV(CLK_DIV), .BASE_ADDR(32'h0001_0000),
    .BASE_MASK(32'hFFFF_0000), .REG_AW(8), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .pio_start(pio_start), .pio_rw(pio_rw),
    .pio_addr_wdata(pio_addr_wdata), .clk_div(clk_div), .pio_ack(pio_ack),
    .pio_rvalid(pio_rvalid), .pio_rdata(pio_rdata), .reg_req(reg_req),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_rdy(reg_rdy), .pio_err(pio_err),
    .pio_drop(pio_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // local register model: answers in the same cycle when enabled
  always_comb begin
    reg_rdy   = reg_req & rdy_en;
    reg_rdata = mem_rdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // per-cycle compare against the rule-level model
  task automatic cycle_check();
    logic exp_div;
    exp_div = rst ? 1'b0 : ((k % CLK_DIV) == (CLK_DIV - 1));
    chk("clk_div", clk_div, exp_div);
    chk("ack_and_rvalid", pio_ack & pio_rvalid, 0);
    if (pio_rvalid) chk("rdata_hold", pio_rdata, exp_rdata);
    if (reg_req) begin
      chk("reg_addr", reg_addr, exp_addr);
      chk("reg_wr", reg_wr, exp_wr);
      if (exp_wr) chk("reg_wdata", reg_wdata, exp_wdata);
    end
    if (clk_div && pio_rvalid) rv_strb++;
    if (clk_div && pio_ack) ack_strb++;
    if (pio_drop) drop_cyc++;
    if (reg_req) req_cyc++;
    if (pio_ack) ack_cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    k = rst ? 0 : k + 1;
    #1;
  endtask

  task automatic drive(input logic s, input logic rw, input logic [31:0] d);
    pio_start = s;
    pio_rw = rw;
    pio_addr_wdata = d;
  endtask

  // wait for the response to fall, then for the strobe that releases DRAIN
  task automatic wait_done();
    int n;
    n = 0;
    while ((pio_rvalid || pio_ack) && n < 4 * CLK_DIV) begin step(); n++; end
    chk("resp_release_bound", (pio_rvalid || pio_ack), 0);
    n = 0;
    do begin step(); n++; end while (!clk_div && n < 2 * CLK_DIV);
    chk("drain_strobe_bound", clk_div, 1);
    chk("drain_rvalid_low", pio_rvalid | pio_ack, 0);
    step();
  endtask

  initial begin
    int n, s0, s1, d0, r0, a0;
    checks = 0; errors = 0; k = 0;
    rv_strb = 0; ack_strb = 0; drop_cyc = 0; req_cyc = 0; ack_cyc = 0;
    rst = 1'b1; rdy_en = 1'b1; mem_rdata = '0;
    exp_rdata = '0; exp_wdata = '0; exp_addr = '0; exp_wr = 1'b0;
    drive(0, 0, '0);

    // reset state
    step(); step();
    chk("rst_outputs", {clk_div, pio_ack, pio_rvalid, reg_req, pio_err, pio_drop}, 0);
    chk("rst_rdata", pio_rdata, 0);
    rst = 1'b0;
    n = 0;
    do begin step(); n++; end while (!clk_div && n < 20);
    chk("first_strobe_edge", n, 3);

    // read with same-cycle reg_rdy
    exp_rdata = 32'hCAFE0001; mem_rdata = 32'hCAFE0001;
    exp_addr = 8'd2; exp_wr = 1'b0; rdy_en = 1'b1;
    s0 = rv_strb; s1 = ack_strb;
    drive(1, 0, 32'h0001_0008);
    step();
    drive(0, 0, '0);
    chk("rd_req", reg_req, 1);
    chk("rd_addr", reg_addr, 2);
    chk("rd_rvalid_early", pio_rvalid, 0);
    step();
    chk("rd_rvalid", pio_rvalid, 1);
    chk("rd_rdata", pio_rdata, 32'hCAFE0001);
    chk("rd_req_dropped", reg_req, 0);
    wait_done();
    chk("rd_rv_strobes", rv_strb - s0, 1);
    chk("rd_ack_strobes", ack_strb - s1, 0);
    chk("rd_rdata_kept", pio_rdata, 32'hCAFE0001);

    // write: address cycle then data cycle
    exp_addr = 8'd1; exp_wr = 1'b1; exp_wdata = 32'h12345678;
    s0 = rv_strb; s1 = ack_strb;
    drive(1, 1, 32'h0001_0004);
    step();
    drive(1, 1, 32'h12345678);
    step();
    drive(0, 0, '0);
    chk("wr_req", reg_req, 1);
    chk("wr_wdata", reg_wdata, 32'h12345678);
    chk("wr_wr", reg_wr, 1);
    step();
    chk("wr_ack", pio_ack, 1);
    wait_done();
    chk("wr_ack_strobes", ack_strb - s1, 1);
    chk("wr_rv_strobes", rv_strb - s0, 0);
    chk("wr_rdata_untouched", pio_rdata, 32'hCAFE0001);

    // address miss
    r0 = req_cyc; d0 = drop_cyc;
    drive(1, 0, 32'h0002_0000);
    step();
    drive(0, 0, '0);
    for (int i = 0; i < 8; i++) step();
    chk("miss_no_req", req_cyc - r0, 0);
    chk("miss_no_drop", drop_cyc - d0, 0);

    // busy: start arriving during ACCESS
    exp_rdata = 32'h0BADF00D; mem_rdata = 32'h0BADF00D;
    exp_addr = 8'd3; exp_wr = 1'b0; rdy_en = 1'b0;
    d0 = drop_cyc;
    drive(1, 0, 32'h0001_000C);
    step();
    drive(1, 1, 32'h0001_0010);
    step();
    drive(0, 0, '0);
    chk("busy_drop", pio_drop, 1);
    step();
    chk("busy_drop_end", pio_drop, 0);
    step();
    rdy_en = 1'b1;
    step();
    chk("busy_rvalid", pio_rvalid, 1);
    chk("busy_rdata", pio_rdata, 32'h0BADF00D);
    wait_done();
    chk("busy_drop_count", drop_cyc - d0, 1);
    chk("busy_no_err", pio_err, 0);

    // malformed write: address cycle only
    r0 = req_cyc; a0 = ack_cyc;
    drive(1, 1, 32'h0001_0004);
    step();
    drive(0, 0, '0);
    for (int i = 0; i < 3 * CLK_DIV; i++) step();
    chk("malformed_no_req", req_cyc - r0, 0);
    chk("malformed_no_ack", ack_cyc - a0, 0);

    // read timeout
    exp_rdata = 32'hFFFFFFFF; exp_addr = 8'd8; exp_wr = 1'b0; rdy_en = 1'b0;
    drive(1, 0, 32'h0001_0020);
    step();
    drive(0, 0, '0);
    n = 0;
    while (reg_req && n < 200) begin n++; step(); end
    chk("to_req_cycles", n, 64);
    chk("to_err", pio_err, 1);
    chk("to_rvalid", pio_rvalid, 1);
    chk("to_rdata", pio_rdata, 32'hFFFFFFFF);
    wait_done();
    chk("to_err_sticky", pio_err, 1);

    // reset during RESP, then a fresh read
    exp_rdata = 32'h55AA55AA; mem_rdata = 32'h55AA55AA; exp_addr = 8'd2; rdy_en = 1'b1;
    drive(1, 0, 32'h0001_0008);
    step();
    drive(0, 0, '0);
    step();
    chk("rr_rvalid_before", pio_rvalid, 1);
    rst = 1'b1; k = 0;
    #1;
    chk("rr_async_clear", {pio_ack, pio_rvalid, reg_req, pio_err}, 0);
    chk("rr_rdata_clear", pio_rdata, 0);
    step(); step();
    rst = 1'b0;
    exp_rdata = 32'h13579BDF; mem_rdata = 32'h13579BDF;
    drive(1, 0, 32'h0001_0008);
    step();
    drive(0, 0, '0);
    step();
    chk("rr_fresh_rvalid", pio_rvalid, 1);
    chk("rr_fresh_rdata", pio_rdata, 32'h13579BDF);
    wait_done();
    chk("rr_no_err", pio_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
